// File: rtl/sort_pkg.sv
// Shared types and constants for the burst sorter: FSM encoding, default sizes, clog2.
// No logic, so no latency and no backpressure.
package sort_pkg;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_SORT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD  = ST_LOAD,
        S_SORT  = ST_SORT,
        S_DRAIN = ST_DRAIN
    } state_t;

    localparam int SORT_N_DEF = 4;
    localparam int SORT_W_DEF = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_swap4.sv
// Unsigned compare-and-swap cell; swaps only on strict b < a so equal values keep their order.
// Purely combinational, zero latency, no backpressure.
module cmp_swap4 #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    logic swap;

    assign swap = (b < a);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/sort4_seq.sv
// Burst sorter: loads N samples, runs N odd-even transposition phases, drains ascending.
// Latency N cycles from last input to first output; stalls only in DRAIN via out_ready.
module sort4_seq
    import sort_pkg::*;
#(
    parameter int N = SORT_N_DEF,
    parameter int W = SORT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int IW = clog2(N) + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state;
    logic [W-1:0]  r      [N];
    logic [W-1:0]  r_ph   [N];
    logic [W-1:0]  lo_v   [N-1];
    logic [W-1:0]  hi_v   [N-1];
    logic [IW-1:0] li;
    logic [IW-1:0] di;
    logic [IW-1:0] pc;
    logic [W-1:0]  rd_sel;

    // One cell per adjacent pair; the phase parity decides which cells commit.
    for (genvar g = 0; g < N - 1; g++) begin : g_cell
        cmp_swap4 #(.W(W)) u_cs (
            .a  (r[g]),
            .b  (r[g+1]),
            .lo (lo_v[g]),
            .hi (hi_v[g])
        );
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            r_ph[i] = r[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (pc[0] == 1'(i % 2)) begin
                r_ph[i]   = lo_v[i];
                r_ph[i+1] = hi_v[i];
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (di == IW'(i)) begin
                rd_sel = r[i];
            end
        end
    end

    assign out_data = out_valid ? rd_sel : '0;
    assign out_last = out_valid && (di == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOAD;
            li        <= '0;
            di        <= '0;
            pc        <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r[i] <= '0;
            end
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        for (int i = 0; i < N; i++) begin
                            if (li == IW'(i)) begin
                                r[i] <= in_data;
                            end
                        end
                        if (li == LAST) begin
                            li       <= '0;
                            pc       <= '0;
                            state    <= S_SORT;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            li <= li + IW'(1);
                        end
                    end
                end
                S_SORT: begin
                    for (int i = 0; i < N; i++) begin
                        r[i] <= r_ph[i];
                    end
                    if (pc == LAST) begin
                        pc        <= '0;
                        di        <= '0;
                        state     <= S_DRAIN;
                        out_valid <= 1'b1;
                    end else begin
                        pc <= pc + IW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (di == LAST) begin
                            di        <= '0;
                            state     <= S_LOAD;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            di <= di + IW'(1);
                        end
                    end
                end
                default: begin
                    state     <= S_LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_seq.sv
// Directed bench for sort4_seq: N=4/W=4 burst table plus reset and N=5/W=8 sequences.
module tb_sort4_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data = 8'd0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [7:0] b_out_data;
    logic       b_out_last;
    logic       b_busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit hold_in  = 1'b0;

    typedef struct {
        logic [3:0] din  [4];
        logic [3:0] dexp [4];
        bit         gaps;
        bit         stall;
        bit         hold;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    logic [7:0] b_seq [5];
    logic [7:0] b_exp [5];

    always #5 clk = ~clk;

    sort4_seq #(.N(4), .W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    sort4_seq #(.N(5), .W(8)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic set_vec(input int i,
                           input logic [3:0] a0, input logic [3:0] a1,
                           input logic [3:0] a2, input logic [3:0] a3,
                           input logic [3:0] e0, input logic [3:0] e1,
                           input logic [3:0] e2, input logic [3:0] e3,
                           input bit gaps, input bit stall, input bit hold);
        vecs[i].din[0]  = a0; vecs[i].din[1]  = a1; vecs[i].din[2]  = a2; vecs[i].din[3]  = a3;
        vecs[i].dexp[0] = e0; vecs[i].dexp[1] = e1; vecs[i].dexp[2] = e2; vecs[i].dexp[3] = e3;
        vecs[i].gaps  = gaps;
        vecs[i].stall = stall;
        vecs[i].hold  = hold;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  1);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"},  32'(out_data),  0);
        check({tag, "_out_last"},  32'(out_last),  0);
        check({tag, "_busy"},      32'(busy),      0);
    endtask

    // Leaves the bench one cycle after the 4th input handshake.
    task automatic load4(input int v);
        int t;
        for (int i = 0; i < 4; i++) begin
            if (vecs[v].gaps) begin
                in_valid = 1'b0;
                in_data  = 4'hB;
                tick();
            end
            in_valid = 1'b1;
            in_data  = vecs[v].din[i];
            t = 0;
            while (!in_ready && t < 50) begin
                tick();
                t++;
            end
            if (!in_ready) check("load_ready_timeout", 32'(in_ready), 1);
            tick();
        end
        in_valid = hold_in;
        in_data  = 4'hE;
    endtask

    task automatic wait_sorted();
        int cyc;
        check("sort_in_ready", 32'(in_ready), 0);
        check("sort_busy",     32'(busy),     1);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check("sort_no_out_valid", 32'(out_valid), 0);
            tick();
            cyc++;
        end
        check("first_out_latency", 32'(cyc), 4);
    endtask

    task automatic drain4(input int v);
        int j;
        int cyc;
        j = 0;
        cyc = 0;
        while (j < 4 && cyc < 60) begin
            out_ready = vecs[v].stall ? (cyc % 3 == 0) : 1'b1;
            check("drain_out_valid", 32'(out_valid), 1);
            check("drain_out_data",  32'(out_data),  32'(vecs[v].dexp[j]));
            check("drain_out_last",  32'(out_last),  (j == 3) ? 1 : 0);
            check("drain_in_ready",  32'(in_ready),  0);
            if (out_ready) j++;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("drain_handshakes",   32'(j),         4);
        check("post_drain_in_rdy",  32'(in_ready),  1);
        check("post_drain_out_vld", 32'(out_valid), 0);
        check("post_drain_busy",    32'(busy),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int j;
        int cyc;

        //        inputs           expected sorted    gaps stall hold
        set_vec(0, 9, 3, 12, 3,    3, 3, 9, 12,       0, 0, 0);
        set_vec(1, 15, 10, 5, 0,   0, 5, 10, 15,      0, 0, 0);
        set_vec(2, 15, 15, 15, 15, 15, 15, 15, 15,    0, 0, 0);
        set_vec(3, 0, 1, 2, 3,     0, 1, 2, 3,        0, 1, 0);
        set_vec(4, 7, 2, 7, 1,     1, 2, 7, 7,        1, 0, 1);
        set_vec(5, 8, 8, 0, 4,     0, 4, 8, 8,        0, 1, 1);
        set_vec(6, 1, 0, 2, 0,     0, 0, 1, 2,        0, 0, 0);
        set_vec(7, 5, 6, 4, 3,     3, 4, 5, 6,        0, 0, 0);

        b_seq[0] = 8'd200; b_seq[1] = 8'd7; b_seq[2] = 8'd7; b_seq[3] = 8'd255; b_seq[4] = 8'd0;
        b_exp[0] = 8'd0;   b_exp[1] = 8'd7; b_exp[2] = 8'd7; b_exp[3] = 8'd200; b_exp[4] = 8'd255;

        #23;
        check_reset_outs("reset_held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_reset_outs("reset_released");

        // Table-driven bursts, back-to-back
        for (int v = 0; v < 6; v++) begin
            hold_in = vecs[v].hold;
            load4(v);
            wait_sorted();
            drain4(v);
        end
        hold_in = 1'b0;

        // Reset during SORT phase 2
        load4(7);
        tick();
        tick();
        check("pre_rst_sort_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outs("rst_sort");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("rst_sort_no_output", 32'(out_valid), 0);
            tick();
        end

        // Reset mid-DRAIN after two outputs
        load4(7);
        wait_sorted();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("pre_rst_drain_data", 32'(out_data), 5);
        #1 rst_n = 1'b0;
        #1 check_reset_outs("rst_drain");
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check_reset_outs("rst_drain_after");

        load4(6);
        wait_sorted();
        drain4(6);

        // N=5, W=8 instance
        b_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = b_seq[i];
            t = 0;
            while (!b_in_ready && t < 50) begin
                tick();
                t++;
            end
            if (!b_in_ready) check("n5_ready_timeout", 32'(b_in_ready), 1);
            tick();
        end
        b_in_valid = 1'b0;
        check("n5_sort_busy", 32'(b_busy), 1);
        cyc = 0;
        while (!b_out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("n5_first_out_latency", 32'(cyc), 5);
        j = 0;
        cyc = 0;
        while (j < 5 && cyc < 20) begin
            check("n5_out_valid", 32'(b_out_valid), 1);
            check("n5_out_data",  32'(b_out_data),  32'(b_exp[j]));
            check("n5_out_last",  32'(b_out_last),  (j == 4) ? 1 : 0);
            j++;
            tick();
            cyc++;
        end
        check("n5_post_out_valid", 32'(b_out_valid), 0);
        check("n5_post_in_ready",  32'(b_in_ready),  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort4_seq.md
# sort4_seq

Sequential sorting stage for a burst of N unsigned W-bit samples, with defaults N=4 and W=4. It accepts samples on a valid/ready input stream and orders them using strict less-than compare-and-swap cells. It then drains them in ascending order on a valid/ready output stream. The block sits downstream of the capture logic and feeds ordered data to the rank/threshold logic.

## Interface
- N, default 4: entries per burst; N ≥ 2.
- W, default 4: sample width in bits, unsigned; W ≥ 1.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  W  sample.
- out_valid  out  1  out_data is valid this cycle.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  W  sorted sample, smallest first.
- out_last  out  1  high with the final (largest) sample of a burst.
- busy  out  1  high in SORT or DRAIN.

## Operation
- Storage: N-entry register array r[0..N-1]. Load index li and drain index di, each ceil(log2 N)+1 bits. Phase counter pc counts 0..N-1.
- States:
  - LOAD: in_ready=1. Each in_valid&in_ready writes r[li] ← in_data and li++. The handshake with li==N-1 moves the FSM to SORT, with pc=0 and li=0.
  - SORT: in_ready=0, out_valid=0. One odd-even transposition phase per cycle.
    - Even pc: compare-swap pairs (0,1), (2,3), …
    - Odd pc: compare-swap pairs (1,2), (3,4), …
    - After the phase with pc==N-1, the FSM moves to DRAIN with di=0.
  - DRAIN: out_valid=1, out_data=r[di], out_last=(di==N-1). Each out_valid&out_ready increments di. The handshake with di==N-1 moves the FSM to LOAD.
- Compare-swap: swap only when r[hi] < r[lo], unsigned and strict. Equal values are never swapped. After N phases r is non-decreasing.
- out_valid stays asserted and out_data stays stable while out_ready=0. No backpressure exists during SORT.
- in_valid while in_ready=0 is ignored; the upstream source holds it.
- Reset values: state=LOAD, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, r[*]=0, li=di=pc=0.
- Reset asserted mid-burst (LOAD/SORT/DRAIN) discards the burst immediately. No partial output follows.

## Timing
- Input throughput: 1 sample/cycle in LOAD.
- Latency: Nth input handshake at edge k → SORT occupies edges k+1..k+N → out_valid high after edge k+N.
- Output throughput: 1 sample/cycle with out_ready held high. DRAIN lasts exactly N handshakes.
- in_ready rises the cycle after the last output handshake, so there is no input/output overlap.
- Minimum burst period with no stalls: 3N cycles.
- out_data and out_last are driven directly from registers and the di index. There is no combinational path from in_* to out_*.

## Structure
- Shared package sort_pkg:
  - state encoding localparams ST_LOAD=2'd0, ST_SORT=2'd1, ST_DRAIN=2'd2
  - default N/W constants
  - clog2 function
- Sub-module cmp_swap4 (parameter W):
  - inputs a, b; outputs lo, hi
  - lo = (b<a) ? b : a, hi = the other value
  - Instantiate N/2 cells on even phases and (N-1)/2 on odd phases, or N-1 cells with per-phase enable.
- Top-level sort4_seq holds the FSM, counters, register array and output mux.

## Test plan
- Basic burst: N=4, W=4. Input 9,3,12,3 with out_ready=1 → outputs 3,3,9,12. out_last high only on 12. First out_valid exactly 4 cycles after the 4th input handshake.
- Reverse and extremes: input 15,10,5,0 → outputs 0,5,10,15. Input 15,15,15,15 → four outputs of 15, no X, ties preserved.
- Backpressure: toggle out_ready 1,0,0,1,… during DRAIN. Each value holds stable while stalled. Exactly 4 handshakes occur. in_ready stays 0 until after the last one.
- Input stall/ignore: gaps in in_valid during LOAD; in_valid held high during SORT/DRAIN → only samples with in_ready=1 are captured. The next burst loads correctly back-to-back.
- Reset mid-operation: assert rst_n=0 during SORT phase 2 and again mid-DRAIN → outputs return to reset values immediately. The next burst of 1,0,2,0 yields 0,0,1,2.
- Parameter sweep: N=5, W=8, input 200,7,7,255,0 → outputs 0,7,7,200,255 with out_last on 255.
